// File: rtl/id_fetch_queue_dec_if.sv
// Fetch-to-decode queue bus: fetch-side push handshake, flush, and decoded result handshake.
// The DUT uses the slave modport; the producer/consumer environment uses master.
interface id_fetch_queue_dec_if #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_inst;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_inst;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [4:0]            rd;
   logic [11:0]           csr_addr;
   logic [XLEN-1:0]       imm;
   logic [2:0]            fmt;
   logic [2:0]            funct3;
   logic                  rd_we;
   logic                  illegal;

   modport master (
      output flush, in_valid, in_inst, in_addr, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, rs1, rs2, rd,
             csr_addr, imm, fmt, funct3, rd_we, illegal
   );

   modport slave (
      input  flush, in_valid, in_inst, in_addr, out_ready,
      output in_ready, out_valid, out_inst, out_addr, rs1, rs2, rd,
             csr_addr, imm, fmt, funct3, rd_we, illegal
   );
endinterface

// File: rtl/id_fetch_queue_dec.sv
// Registered RV32I decode stage: DEPTH-entry instruction FIFO, head decoder, and an
// output register behind a valid/ready handshake, with single-cycle flush.
module id_fetch_queue_dec #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                clk,
   input  logic                rst,
   id_fetch_queue_dec_if.slave q_if
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_IL  = 3'd2,
      FMT_S   = 3'd3,
      FMT_B   = 3'd4,
      FMT_U   = 3'd5,
      FMT_J   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [31:0]           r_inst_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  r_out_valid;
   logic [31:0]           r_out_inst;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic [4:0]            r_rs1;
   logic [4:0]            r_rs2;
   logic [4:0]            r_rd;
   logic [11:0]           r_csr_addr;
   logic [XLEN-1:0]       r_imm;
   logic [2:0]            r_fmt;
   logic [2:0]            r_funct3;
   logic                  r_rd_we;
   logic                  r_illegal;

   logic                  w_in_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [31:0]           w_head;
   fmt_e                  w_fmt;
   logic [4:0]            w_rs1;
   logic [4:0]            w_rs2;
   logic [4:0]            w_rd;
   logic [11:0]           w_csr_addr;
   logic [XLEN-1:0]       w_imm;
   logic [2:0]            w_funct3;
   logic                  w_illegal;

   assign w_in_ready = (r_count != FULL_CNT);
   assign w_push     = q_if.in_valid && w_in_ready;
   assign w_pop      = (r_count != CNT_W'(0)) && (!r_out_valid || q_if.out_ready);
   assign w_head     = r_inst_mem[r_rd_ptr];

   // Decode the FIFO head; fields unused by the format stay zero
   always_comb begin
      w_rs1      = 5'd0;
      w_rs2      = 5'd0;
      w_rd       = 5'd0;
      w_imm      = {XLEN{1'b0}};
      w_funct3   = 3'd0;
      w_illegal  = 1'b0;
      w_csr_addr = 12'd0;
      case (w_head[6:0])
         7'b0110011:                         w_fmt = FMT_R;
         7'b0010011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
         7'b0000011:                         w_fmt = FMT_IL;
         7'b0100011:                         w_fmt = FMT_S;
         7'b1100011:                         w_fmt = FMT_B;
         7'b0110111, 7'b0010111:             w_fmt = FMT_U;
         7'b1101111:                         w_fmt = FMT_J;
         default:                            w_fmt = FMT_ILL;
      endcase
      case (w_fmt)
         FMT_R: begin
            w_rs1    = w_head[19:15];
            w_rs2    = w_head[24:20];
            w_rd     = w_head[11:7];
            w_funct3 = w_head[14:12];
         end
         FMT_I, FMT_IL: begin
            w_rs1    = w_head[19:15];
            w_rd     = w_head[11:7];
            w_funct3 = w_head[14:12];
            w_imm    = sext32({{20{w_head[31]}}, w_head[31:20]});
         end
         FMT_S: begin
            w_rs1    = w_head[19:15];
            w_rs2    = w_head[24:20];
            w_funct3 = w_head[14:12];
            w_imm    = sext32({{20{w_head[31]}}, w_head[31:25], w_head[11:7]});
         end
         FMT_B: begin
            w_rs1    = w_head[19:15];
            w_rs2    = w_head[24:20];
            w_funct3 = w_head[14:12];
            w_imm    = sext32({{19{w_head[31]}}, w_head[31], w_head[7],
                               w_head[30:25], w_head[11:8], 1'b0});
         end
         FMT_U: begin
            w_rd  = w_head[11:7];
            w_imm = sext32({w_head[31:12], 12'd0});
         end
         FMT_J: begin
            w_rd  = w_head[11:7];
            w_imm = sext32({{11{w_head[31]}}, w_head[31], w_head[19:12],
                            w_head[20], w_head[30:21], 1'b0});
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
      if (w_head[6:0] == 7'b1110011) begin
         w_csr_addr = w_head[31:20];
      end else begin
         w_csr_addr = 12'd0;
      end
   end

   // FIFO storage; payload needs no reset because only counted entries are ever read
   always_ff @(posedge clk) begin
      if (rst && !q_if.flush && w_push) begin
         r_inst_mem[r_wr_ptr] <= q_if.in_inst;
         r_addr_mem[r_wr_ptr] <= q_if.in_addr;
      end
   end

   // Pointers, occupancy and the output register; reset beats flush beats traffic
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_inst  <= 32'd0;
         r_out_addr  <= '0;
         r_rs1       <= 5'd0;
         r_rs2       <= 5'd0;
         r_rd        <= 5'd0;
         r_csr_addr  <= 12'd0;
         r_imm       <= '0;
         r_fmt       <= 3'd0;
         r_funct3    <= 3'd0;
         r_rd_we     <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (q_if.flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            r_out_valid <= 1'b1;
            r_out_inst  <= w_head;
            r_out_addr  <= r_addr_mem[r_rd_ptr];
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_csr_addr  <= w_csr_addr;
            r_imm       <= w_imm;
            r_fmt       <= w_fmt;
            r_funct3    <= w_funct3;
            r_rd_we     <= (w_rd != 5'd0);
            r_illegal   <= w_illegal;
         end else if (q_if.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign q_if.in_ready  = w_in_ready;
   assign q_if.out_valid = r_out_valid;
   assign q_if.out_inst  = r_out_inst;
   assign q_if.out_addr  = r_out_addr;
   assign q_if.rs1       = r_rs1;
   assign q_if.rs2       = r_rs2;
   assign q_if.rd        = r_rd;
   assign q_if.csr_addr  = r_csr_addr;
   assign q_if.imm       = r_imm;
   assign q_if.fmt       = r_fmt;
   assign q_if.funct3    = r_funct3;
   assign q_if.rd_we     = r_rd_we;
   assign q_if.illegal   = r_illegal;
endmodule

// File: tb/tb_id_fetch_queue_dec.sv
// Bench for id_fetch_queue_dec: directed decode and handshake scenarios plus random
// traffic, compared every cycle against a queue-based model of the stage.
module tb_id_fetch_queue_dec;
   localparam int XLEN  = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   id_fetch_queue_dec_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) q_if ();

   id_fetch_queue_dec #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .q_if (q_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [11:0] csr;
      logic [31:0] imm;
      logic [2:0]  funct3;
      logic        rd_we;
      logic        illegal;
   } dec_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the RV32I field rules, using arithmetic on the word
   function automatic dec_t ref_dec(input logic [31:0] w);
      dec_t d;
      bit   use1, use2, used;
      d = '0;
      case (w[6:0])
         7'h33:               d.fmt = 3'd0;
         7'h13, 7'h67, 7'h73: d.fmt = 3'd1;
         7'h03:               d.fmt = 3'd2;
         7'h23:               d.fmt = 3'd3;
         7'h63:               d.fmt = 3'd4;
         7'h37, 7'h17:        d.fmt = 3'd5;
         7'h6F:               d.fmt = 3'd6;
         default:             d.fmt = 3'd7;
      endcase
      if (d.fmt == 3'd7) begin
         d.illegal = 1'b1;
         return d;
      end
      case (d.fmt)
         3'd1, 3'd2: d.imm = 32'($signed(w) >>> 20);
         3'd3: d.imm = 32'((($signed(w) >>> 25) * 32) + int'(w[11:7]));
         3'd4: d.imm = 32'((($signed(w) >>> 31) * 4096) + int'(w[7]) * 2048
                           + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
         3'd5: d.imm = w & 32'hFFFFF000;
         3'd6: d.imm = 32'((($signed(w) >>> 31) * (1 << 20)) + int'(w[19:12]) * 4096
                           + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
         default: d.imm = 32'd0;
      endcase
      use1     = (d.fmt <= 3'd4);
      use2     = (d.fmt == 3'd0) || (d.fmt == 3'd3) || (d.fmt == 3'd4);
      used     = (d.fmt <= 3'd2) || (d.fmt == 3'd5) || (d.fmt == 3'd6);
      d.rs1    = use1 ? w[19:15] : 5'd0;
      d.rs2    = use2 ? w[24:20] : 5'd0;
      d.rd     = used ? w[11:7] : 5'd0;
      d.csr    = (w[6:0] == 7'h73) ? w[31:20] : 12'd0;
      d.funct3 = (d.fmt < 3'd5) ? w[14:12] : 3'd0;
      d.rd_we  = used && (w[11:7] != 5'd0);
      return d;
   endfunction

   // Model: plain queue for the FIFO plus one output slot
   logic [31:0]   m_qi [$];
   logic [AW-1:0] m_qa [$];
   bit            m_ov = 1'b0;
   logic [31:0]   m_inst;
   logic [AW-1:0] m_addr;

   always @(posedge clk) begin : model
      bit push, pop;
      if (!rst || q_if.flush) begin
         m_qi.delete();
         m_qa.delete();
         m_ov = 1'b0;
      end else begin
         push = q_if.in_valid && (m_qi.size() < DEPTH);
         pop  = (m_qi.size() > 0) && (!m_ov || q_if.out_ready);
         if (pop) begin
            m_inst = m_qi.pop_front();
            m_addr = m_qa.pop_front();
            m_ov   = 1'b1;
         end else if (q_if.out_ready) begin
            m_ov = 1'b0;
         end
         if (push) begin
            m_qi.push_back(q_if.in_inst);
            m_qa.push_back(q_if.in_addr);
         end
      end
   end

   bit          rec = 1'b0;
   logic [31:0] seen [$];

   always @(negedge clk) begin : compare
      dec_t e;
      chk("out_valid", q_if.out_valid, m_ov);
      chk("in_ready", q_if.in_ready, m_qi.size() != DEPTH);
      if (m_ov) begin
         e = ref_dec(m_inst);
         chk("out_inst", q_if.out_inst, m_inst);
         chk("out_addr", q_if.out_addr, m_addr);
         chk("fmt", q_if.fmt, e.fmt);
         chk("rs1", q_if.rs1, e.rs1);
         chk("rs2", q_if.rs2, e.rs2);
         chk("rd", q_if.rd, e.rd);
         chk("csr_addr", q_if.csr_addr, e.csr);
         chk("imm", q_if.imm, e.imm);
         chk("funct3", q_if.funct3, e.funct3);
         chk("rd_we", q_if.rd_we, e.rd_we);
         chk("illegal", q_if.illegal, e.illegal);
      end
      if (rec && q_if.out_valid && q_if.out_ready && rst && !q_if.flush) begin
         seen.push_back(q_if.out_inst);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, q_if.out_valid, 1'b0);
      chk({tag, "_in_ready"}, q_if.in_ready, 1'b1);
      chk({tag, "_fmt"}, q_if.fmt, 3'd0);
      chk({tag, "_imm"}, q_if.imm, 32'd0);
      chk({tag, "_rs1"}, q_if.rs1, 5'd0);
      chk({tag, "_rd"}, q_if.rd, 5'd0);
      chk({tag, "_rd_we"}, q_if.rd_we, 1'b0);
      chk({tag, "_illegal"}, q_if.illegal, 1'b0);
      chk({tag, "_out_inst"}, q_if.out_inst, 32'd0);
   endtask

   // One instruction through an idle stage: visible exactly two edges after it is offered
   task automatic dir1(input string tag, input logic [31:0] w, input logic [AW-1:0] a,
                       input logic [2:0] f, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [2:0] f3, input logic [31:0] im,
                       input logic we, input logic il);
      q_if.out_ready = 1'b1;
      q_if.in_valid  = 1'b1;
      q_if.in_inst   = w;
      q_if.in_addr   = a;
      tick();
      q_if.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, q_if.out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, q_if.out_valid, 1'b1);
      chk({tag, "_inst"}, q_if.out_inst, w);
      chk({tag, "_addr"}, q_if.out_addr, a);
      chk({tag, "_fmt"}, q_if.fmt, f);
      chk({tag, "_rs1"}, q_if.rs1, s1);
      chk({tag, "_rs2"}, q_if.rs2, s2);
      chk({tag, "_rd"}, q_if.rd, d);
      chk({tag, "_funct3"}, q_if.funct3, f3);
      chk({tag, "_imm"}, q_if.imm, im);
      chk({tag, "_rd_we"}, q_if.rd_we, we);
      chk({tag, "_illegal"}, q_if.illegal, il);
      tick();
   endtask

   logic [31:0] w6 [6];
   logic [31:0] sw [2*DEPTH];

   initial begin
      dec_t        d;
      logic [31:0] rnd;
      logic [6:0]  ops [9];
      ops = '{7'h33, 7'h13, 7'h67, 7'h73, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};

      rst            = 1'b0;
      q_if.flush     = 1'b0;
      q_if.in_valid  = 1'b0;
      q_if.in_inst   = 32'd0;
      q_if.in_addr   = '0;
      q_if.out_ready = 1'b0;

      d = ref_dec(32'h00110093);
      chk("model_addi_fmt", d.fmt, 3'd1);
      chk("model_addi_imm", d.imm, 32'h1);
      chk("model_addi_rs1", d.rs1, 5'd2);
      d = ref_dec(32'hFE20D8E3);
      chk("model_bge_imm", d.imm, 32'hFFFFFFF0);
      chk("model_bge_funct3", d.funct3, 3'd5);
      d = ref_dec(32'h123452B7);
      chk("model_lui_imm", d.imm, 32'h12345000);
      chk("model_lui_rd", d.rd, 5'd5);
      d = ref_dec(32'h00000000);
      chk("model_zero_illegal", d.illegal, 1'b1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("rst0");
      tick();
      rst = 1'b1;

      dir1("addi", 32'h00110093, 32'h100, 3'd1, 5'd2, 5'd0, 5'd1, 3'd0, 32'h1, 1'b1, 1'b0);
      dir1("bge", 32'hFE20D8E3, 32'h104, 3'd4, 5'd1, 5'd2, 5'd0, 3'd5, 32'hFFFFFFF0, 1'b0, 1'b0);
      dir1("lui", 32'h123452B7, 32'h108, 3'd5, 5'd0, 5'd0, 5'd5, 3'd0, 32'h12345000, 1'b1, 1'b0);
      dir1("zero", 32'h00000000, 32'h10C, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1);
      dir1("addi2", 32'h00110093, 32'h110, 3'd1, 5'd2, 5'd0, 5'd1, 3'd0, 32'h1, 1'b1, 1'b0);

      // Capacity: DEPTH+1 words held with the consumer stalled
      q_if.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         w6[k]         = 32'h00000093 | (32'(k + 1) << 20);
         q_if.in_valid = 1'b1;
         q_if.in_inst  = w6[k];
         q_if.in_addr  = 32'h200 + 32'(4 * k);
         tick();
         if (k == 3) chk("cap_ready_at4", q_if.in_ready, 1'b1);
         if (k == 4) chk("cap_full_at5", q_if.in_ready, 1'b0);
      end
      q_if.in_valid = 1'b0;
      @(negedge clk);
      chk("cap_still_full", q_if.in_ready, 1'b0);
      tick();
      q_if.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("cap_drain_valid", q_if.out_valid, 1'b1);
         chk("cap_drain_order", q_if.out_inst, w6[k]);
         tick();
      end
      @(negedge clk);
      chk("cap_empty_valid", q_if.out_valid, 1'b0);
      chk("cap_empty_ready", q_if.in_ready, 1'b1);
      tick();

      // Flush with three queued entries and a push offered in the same cycle
      q_if.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         q_if.in_valid = 1'b1;
         q_if.in_inst  = w6[k];
         tick();
      end
      q_if.flush    = 1'b1;
      q_if.in_inst  = 32'h7FF00093;
      tick();
      q_if.flush    = 1'b0;
      q_if.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", q_if.out_valid, 1'b0);
      chk("flush_ready", q_if.in_ready, 1'b1);
      tick();
      q_if.out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("flush_nostale", q_if.out_valid, 1'b0);
         tick();
      end

      // Reset with a full stage, then stream across pointer wrap-around
      q_if.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         q_if.in_valid = 1'b1;
         q_if.in_inst  = w6[k];
         tick();
      end
      q_if.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("rst1");
      tick();
      rec            = 1'b1;
      q_if.out_ready = 1'b1;
      for (int k = 0; k < 2 * DEPTH; k++) begin
         sw[k]         = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
         q_if.in_valid = 1'b1;
         q_if.in_inst  = sw[k];
         q_if.in_addr  = 32'h400 + 32'(4 * k);
         tick();
      end
      q_if.in_valid = 1'b0;
      repeat (4) tick();
      rec = 1'b0;
      chk("wrap_count", seen.size(), 2 * DEPTH);
      for (int k = 0; k < 2 * DEPTH; k++) begin
         if (k < seen.size()) chk("wrap_order", seen[k], sw[k]);
      end

      // Random traffic with occasional flush and reset
      repeat (3000) begin
         rnd = $urandom;
         if ($urandom_range(0, 9) != 0) begin
            rnd[6:0] = ops[$urandom_range(0, 8)];
         end
         q_if.in_valid  = ($urandom_range(0, 3) != 0);
         q_if.out_ready = ($urandom_range(0, 2) != 0);
         q_if.flush     = ($urandom_range(0, 39) == 0);
         rst            = ($urandom_range(0, 149) != 0);
         q_if.in_inst   = rnd;
         q_if.in_addr   = $urandom;
         tick();
      end
      rst            = 1'b1;
      q_if.flush     = 1'b0;
      q_if.in_valid  = 1'b0;
      q_if.out_ready = 1'b1;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
